// File: rtl/stopwatch_sec_digits_if.sv
// Control and digit bundle for the seconds stage of the stopwatch.
// The master side drives tick and controls, and the slave side returns the BCD digits and status.
interface stopwatch_sec_digits_if;
  logic       tick;
  logic       start;
  logic       stop;
  logic       clear;
  logic       up;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       carry;
  logic       running;

  modport master (
    output tick, start, stop, clear, up,
    input  ones, tens, carry, running
  );

  modport slave (
    input  tick, start, stop, clear, up,
    output ones, tens, carry, running
  );
endinterface

// File: rtl/stopwatch_sec_digits.sv
// Two-digit BCD seconds counter (00-59) with run/pause/clear and up/down direction.
// carry pulses for one cycle on a wrap and drives the minutes stage.
//
//   state | meaning
//   IDLE  | cleared, waiting for start
//   RUN   | prescaler counts ticks, digits step
//   PAUSE | digits and prescaler frozen, waiting for start
module stopwatch_sec_digits #(
  parameter int TICK_DIV = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stopwatch_sec_digits_if.slave sw
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    ones_q;
  logic [3:0]    tens_q;
  logic          carry_q;
  logic          running_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      presc     <= '0;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      carry_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      carry_q <= 1'b0;
      if (sw.clear) begin
        state     <= IDLE;
        presc     <= '0;
        ones_q    <= 4'd0;
        tens_q    <= 4'd0;
        running_q <= 1'b0;
      end else begin
        case (state)
          IDLE, PAUSE: begin
            // stop outranks start, so a simultaneous start is dropped
            if (sw.start && !sw.stop) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            if (sw.stop) begin
              state     <= PAUSE;
              running_q <= 1'b0;
            end else if (sw.tick) begin
              if (presc == PRESC_MAX) begin
                presc <= '0;
                if (sw.up) begin
                  if (ones_q != 4'd9) begin
                    ones_q <= ones_q + 4'd1;
                  end else begin
                    ones_q <= 4'd0;
                    if (tens_q != 4'd5) begin
                      tens_q <= tens_q + 4'd1;
                    end else begin
                      tens_q  <= 4'd0;
                      carry_q <= 1'b1;
                    end
                  end
                end else begin
                  if (ones_q != 4'd0) begin
                    ones_q <= ones_q - 4'd1;
                  end else begin
                    ones_q <= 4'd9;
                    if (tens_q != 4'd0) begin
                      tens_q <= tens_q - 4'd1;
                    end else begin
                      tens_q  <= 4'd5;
                      carry_q <= 1'b1;
                    end
                  end
                end
              end else begin
                presc <= presc + 1'b1;
              end
            end
          end
          default: begin
            state     <= IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sw.ones    = ones_q;
  assign sw.tens    = tens_q;
  assign sw.carry   = carry_q;
  assign sw.running = running_q;

  a_bcd_range: assert property (@(posedge clk) disable iff (!rst_n)
    (ones_q <= 4'd9) && (tens_q <= 4'd5));
endmodule

// File: tb/tb_stopwatch_sec_digits.sv
// Bench for stopwatch_sec_digits: one instance with TICK_DIV=4 and one with TICK_DIV=1.
// Output changes are matched in order against queued expected tuples {tens, ones, carry, running}.
module tb_stopwatch_sec_digits;
  logic clk = 1'b0;
  logic rst4_n = 1'b1;
  logic rst1_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stopwatch_sec_digits_if b4 ();
  stopwatch_sec_digits_if b1 ();

  stopwatch_sec_digits #(.TICK_DIV(4)) dut4 (.clk(clk), .rst_n(rst4_n), .sw(b4.slave));
  stopwatch_sec_digits #(.TICK_DIV(1)) dut1 (.clk(clk), .rst_n(rst1_n), .sw(b1.slave));

  logic [9:0] q4[$];
  logic [9:0] q1[$];

  function automatic logic [9:0] tup(input int t, input int o, input bit c, input bit r);
    return {4'(t), 4'(o), c, r};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitors: every change in the output tuple consumes one expected entry
  logic [9:0] prev4 = '0;
  logic [9:0] prev1 = '0;
  always @(negedge clk) begin
    logic [9:0] cur;
    logic [9:0] exp;
    cur = {b4.tens, b4.ones, b4.carry, b4.running};
    if (!$isunknown(cur)) begin
      if (cur != prev4) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL event4 unexpected change to %h", cur);
        end else begin
          exp = q4.pop_front();
          if (cur != exp) begin
            errors++;
            $display("FAIL event4 got %h expected %h", cur, exp);
          end
        end
      end
      prev4 = cur;
    end
  end

  always @(negedge clk) begin
    logic [9:0] cur;
    logic [9:0] exp;
    cur = {b1.tens, b1.ones, b1.carry, b1.running};
    if (!$isunknown(cur)) begin
      if (cur != prev1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL event1 unexpected change to %h", cur);
        end else begin
          exp = q1.pop_front();
          if (cur != exp) begin
            errors++;
            $display("FAIL event1 got %h expected %h", cur, exp);
          end
        end
      end
      prev1 = cur;
    end
  end

  task automatic drv4(input logic tk, input logic st, input logic sp, input logic cl, input logic u);
    @(posedge clk);
    #1;
    b4.tick = tk; b4.start = st; b4.stop = sp; b4.clear = cl; b4.up = u;
  endtask

  task automatic drv1(input logic tk, input logic st, input logic sp, input logic cl, input logic u);
    @(posedge clk);
    #1;
    b1.tick = tk; b1.start = st; b1.stop = sp; b1.clear = cl; b1.up = u;
  endtask

  initial begin
    int sec;
    b4.tick = 0; b4.start = 0; b4.stop = 0; b4.clear = 0; b4.up = 1;
    b1.tick = 0; b1.start = 0; b1.stop = 0; b1.clear = 0; b1.up = 1;
    #2;
    rst4_n = 1'b0;
    rst1_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("reset_ones", int'(b4.ones), 0);
    chk("reset_running", int'(b4.running), 0);
    rst4_n = 1'b1;
    rst1_n = 1'b1;

    // 1: TICK_DIV=4, start then 8 ticks up
    drv4(0, 1, 0, 0, 1); q4.push_back(tup(0, 0, 0, 1));
    for (int i = 1; i <= 8; i++) begin
      drv4(1, 0, 0, 0, 1);
      if (i % 4 == 0) q4.push_back(tup(0, i / 4, 0, 1));
    end
    drv4(0, 0, 0, 0, 1);
    chk("t1_running", int'(b4.running), 1);
    chk("t1_ones", int'(b4.ones), 2);
    chk("t1_tens", int'(b4.tens), 0);

    // 4: prescaler holds its count across a pause
    drv4(0, 0, 0, 1, 1); q4.push_back(tup(0, 0, 0, 0));
    drv4(0, 1, 0, 0, 1); q4.push_back(tup(0, 0, 0, 1));
    for (int i = 1; i <= 6; i++) begin
      drv4(1, 0, 0, 0, 1);
      if (i == 4) q4.push_back(tup(0, 1, 0, 1));
    end
    drv4(0, 0, 1, 0, 1); q4.push_back(tup(0, 1, 0, 0));
    for (int i = 0; i < 10; i++) drv4(1, 0, 0, 0, 1);
    drv4(0, 1, 0, 0, 1); q4.push_back(tup(0, 1, 0, 1));
    drv4(1, 0, 0, 0, 1);
    drv4(1, 0, 0, 0, 1); q4.push_back(tup(0, 2, 0, 1));
    drv4(0, 0, 0, 0, 1);
    chk("t4_ones", int'(b4.ones), 2);
    chk("t4_running", int'(b4.running), 1);

    // 6: count to 0:45, leave a step pending, then async reset
    drv4(0, 0, 0, 1, 1); q4.push_back(tup(0, 0, 0, 0));
    drv4(0, 1, 0, 0, 1); q4.push_back(tup(0, 0, 0, 1));
    sec = 0;
    for (int i = 1; i <= 180; i++) begin
      drv4(1, 0, 0, 0, 1);
      if (i % 4 == 0) begin
        sec++;
        q4.push_back(tup(sec / 10, sec % 10, 0, 1));
      end
    end
    for (int i = 0; i < 3; i++) drv4(1, 0, 0, 0, 1);
    drv4(0, 0, 0, 0, 1);
    chk("t6_pre_tens", int'(b4.tens), 4);
    chk("t6_pre_ones", int'(b4.ones), 5);
    drv4(1, 0, 0, 0, 1);
    #2;
    q4.push_back(tup(0, 0, 0, 0));
    rst4_n = 1'b0;
    #1;
    chk("t6_async_ones", int'(b4.ones), 0);
    chk("t6_async_tens", int'(b4.tens), 0);
    chk("t6_async_carry", int'(b4.carry), 0);
    chk("t6_async_running", int'(b4.running), 0);
    drv4(0, 0, 0, 0, 1);
    drv4(0, 0, 0, 0, 1);
    #2;
    rst4_n = 1'b1;
    drv4(0, 1, 0, 0, 1); q4.push_back(tup(0, 0, 0, 1));
    for (int i = 1; i <= 4; i++) drv4(1, 0, 0, 0, 1);
    q4.push_back(tup(0, 1, 0, 1));
    drv4(0, 0, 0, 0, 1);
    drv4(0, 0, 0, 0, 1);
    chk("t6_post_ones", int'(b4.ones), 1);
    chk("t6_post_carry", int'(b4.carry), 0);

    // 2: TICK_DIV=1, up to 0:59 then wrap
    drv1(0, 1, 0, 0, 1); q1.push_back(tup(0, 0, 0, 1));
    for (int i = 1; i <= 59; i++) begin
      drv1(1, 0, 0, 0, 1);
      q1.push_back(tup(i / 10, i % 10, 0, 1));
    end
    drv1(0, 0, 0, 0, 1);
    chk("t2_tens59", int'(b1.tens), 5);
    chk("t2_ones59", int'(b1.ones), 9);
    drv1(1, 0, 0, 0, 1);
    q1.push_back(tup(0, 0, 1, 1));
    q1.push_back(tup(0, 0, 0, 1));
    drv1(0, 0, 0, 0, 1);
    chk("t2_wrap_carry", int'(b1.carry), 1);
    chk("t2_wrap_ones", int'(b1.ones), 0);
    chk("t2_wrap_tens", int'(b1.tens), 0);
    drv1(0, 0, 0, 0, 1);
    chk("t2_carry_drop", int'(b1.carry), 0);

    // 3: count down from 00 wraps to 59 with a carry
    drv1(0, 0, 0, 1, 0); q1.push_back(tup(0, 0, 0, 0));
    drv1(0, 1, 0, 0, 0); q1.push_back(tup(0, 0, 0, 1));
    drv1(1, 0, 0, 0, 0);
    q1.push_back(tup(5, 9, 1, 1));
    q1.push_back(tup(5, 9, 0, 1));
    drv1(0, 0, 0, 0, 0);
    chk("t3_borrow_carry", int'(b1.carry), 1);
    chk("t3_borrow_tens", int'(b1.tens), 5);
    chk("t3_borrow_ones", int'(b1.ones), 9);
    drv1(0, 0, 0, 0, 0);
    drv1(1, 0, 0, 0, 0); q1.push_back(tup(5, 8, 0, 1));
    drv1(0, 0, 0, 0, 0);
    chk("t3_next_ones", int'(b1.ones), 8);
    chk("t3_next_carry", int'(b1.carry), 0);

    // 5: clear + stop + tick together in RUN at 0:37
    drv1(0, 0, 0, 1, 1); q1.push_back(tup(0, 0, 0, 0));
    drv1(0, 1, 0, 0, 1); q1.push_back(tup(0, 0, 0, 1));
    for (int i = 1; i <= 37; i++) begin
      drv1(1, 0, 0, 0, 1);
      q1.push_back(tup(i / 10, i % 10, 0, 1));
    end
    drv1(1, 0, 1, 1, 1); q1.push_back(tup(0, 0, 0, 0));
    drv1(0, 0, 0, 0, 1);
    chk("t5_ones", int'(b1.ones), 0);
    chk("t5_tens", int'(b1.tens), 0);
    chk("t5_running", int'(b1.running), 0);
    chk("t5_carry", int'(b1.carry), 0);
    for (int i = 0; i < 3; i++) drv1(1, 0, 0, 0, 1);
    drv1(0, 0, 0, 0, 1);
    chk("t5_idle_ones", int'(b1.ones), 0);

    repeat (4) drv1(0, 0, 0, 0, 1);
    chk("q4_drained", q4.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
